// File: rtl/rv_stream_fixed_arb_pkg.sv
// Shared types and helpers for the fixed-priority stream arbiter.
package rv_stream_fixed_arb_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   // Index width is kept at least one bit so a single-stream build still has a sel port.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rv_stream_fixed_arb_if.sv
// N:1 stream bundle: per-stream request side plus the single registered output side.
interface rv_stream_fixed_arb_if #(
   parameter int NUM_REQS     = 4,
   parameter int DATAW        = 32,
   parameter int LOG_NUM_REQS = rv_stream_fixed_arb_pkg::idx_width(NUM_REQS)
) ();

   logic [NUM_REQS-1:0]       valid_in;
   logic [NUM_REQS*DATAW-1:0] data_in;
   logic [NUM_REQS-1:0]       last_in;
   logic [NUM_REQS-1:0]       ready_in;
   logic                      valid_out;
   logic [DATAW-1:0]          data_out;
   logic                      last_out;
   logic [LOG_NUM_REQS-1:0]   sel_out;
   logic                      ready_out;

   modport slave (
      input  valid_in, data_in, last_in, ready_out,
      output ready_in, valid_out, data_out, last_out, sel_out
   );

   modport master (
      output valid_in, data_in, last_in, ready_out,
      input  ready_in, valid_out, data_out, last_out, sel_out
   );

endinterface

// File: rtl/rv_stream_fixed_arb_fixed_arbiter.sv
// Combinational fixed-priority picker: the lowest-index set request wins.
module rv_stream_fixed_arb_fixed_arbiter #(
   parameter int NUM_REQS     = 4,
   parameter int LOG_NUM_REQS = rv_stream_fixed_arb_pkg::idx_width(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0]     requests_i,
   output logic [LOG_NUM_REQS-1:0] grant_index_o,
   output logic [NUM_REQS-1:0]     grant_onehot_o,
   output logic                    grant_valid_o
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      grant_index_o  = '0;
      grant_onehot_o = '0;
      grant_valid_o  = 1'b0;
      // Scan downwards so the last match, i.e. the lowest index, is the one that sticks.
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
         if (requests_i[i]) begin
            grant_index_o     = LOG_NUM_REQS'(i);
            grant_onehot_o    = '0;
            grant_onehot_o[i] = 1'b1;
            grant_valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rv_stream_fixed_arb.sv
// Fixed-priority N:1 stream arbiter with a one-deep output register and optional packet lock.
module rv_stream_fixed_arb
   import rv_stream_fixed_arb_pkg::*;
#(
   parameter int NUM_REQS     = 4,
   parameter int DATAW        = 32,
   parameter int LOCK_ENABLE  = 1,
   parameter int LOG_NUM_REQS = idx_width(NUM_REQS)
) (
   input  logic                 clk,
   input  logic                 reset,
   rv_stream_fixed_arb_if.slave bus
);

   arb_state_e              state_q, state_d;
   logic [LOG_NUM_REQS-1:0] lock_idx_q, lock_idx_d;
   logic                    valid_q, valid_d;
   logic [DATAW-1:0]        data_q, data_d;
   logic                    last_q, last_d;
   logic [LOG_NUM_REQS-1:0] sel_q, sel_d;

   logic [NUM_REQS-1:0]     elig;
   logic [NUM_REQS-1:0]     grant_onehot;
   logic [LOG_NUM_REQS-1:0] grant_index;
   logic                    grant_valid;
   logic                    stage_ready;
   logic                    fire;
   logic [DATAW-1:0]        grant_data;
   logic                    grant_last;

   // While locked only the owner may be granted, even if it is idle this cycle.
   always_comb begin
      elig = bus.valid_in;
      if (state_q == ST_LOCKED) begin
         elig = bus.valid_in & (NUM_REQS'(1) << lock_idx_q);
      end
   end

   rv_stream_fixed_arb_fixed_arbiter #(
      .NUM_REQS     (NUM_REQS),
      .LOG_NUM_REQS (LOG_NUM_REQS)
   ) u_arbiter (
      .requests_i     (elig),
      .grant_index_o  (grant_index),
      .grant_onehot_o (grant_onehot),
      .grant_valid_o  (grant_valid)
   );

   assign stage_ready  = !valid_q | bus.ready_out;
   assign fire         = grant_valid & stage_ready;
   assign bus.ready_in = reset ? '0 : (grant_onehot & {NUM_REQS{stage_ready}});
   assign grant_data   = bus.data_in[int'(grant_index)*DATAW +: DATAW];
   assign grant_last   = bus.last_in[grant_index];

   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      valid_d    = valid_q;
      data_d     = data_q;
      last_d     = last_q;
      sel_d      = sel_q;
      if (stage_ready) begin
         valid_d = fire;
      end
      if (fire) begin
         data_d = grant_data;
         last_d = grant_last;
         sel_d  = grant_index;
         // A fire while locked is always from the owner, so last_in of the grant ends the packet.
         if (LOCK_ENABLE != 0) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (!grant_last) begin
                     state_d    = ST_LOCKED;
                     lock_idx_d = grant_index;
                  end
               end
               ST_LOCKED: begin
                  if (grant_last) begin
                     state_d = ST_IDLE;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q    <= ST_IDLE;
         lock_idx_q <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         last_q     <= 1'b0;
         sel_q      <= '0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         last_q     <= last_d;
         sel_q      <= sel_d;
      end
   end

   assign bus.valid_out = valid_q;
   assign bus.data_out  = data_q;
   assign bus.last_out  = last_q;
   assign bus.sel_out   = sel_q;

endmodule
